// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame path: byte width, dispatcher FSM
// encoding, the default-width frame record and the destination-index helper.
package uart_pkg;

    localparam int BYTE_SIZE    = 8;
    localparam int FRAME_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_OFFER = 2'd2,
        ST_DROP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [BYTE_SIZE-1:0]    opt;
        logic [BYTE_SIZE-1:0]    len;
        logic [FRAME_DATA_W-1:0] data;
    } frame_t;

    // Bits needed to index one of num_dst consumers (at least one bit).
    function automatic int dst_w(input int num_dst);
        return (num_dst > 1) ? $clog2(num_dst) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_fifo.sv
// Small synchronous frame FIFO with a registered read port. A pop loads the
// head entry into rdata_o, which then holds until the next pop. A push into a
// full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_frame_fifo #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW + 1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = rdata_q;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage and registered head read; data is not reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
        if (do_pop)  rdata_q         <= mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/uart_rx_dispatch.sv
// Frame dispatcher behind the UART receiver. Buffers decoded frames, checks
// each one for a valid destination and length, offers it on a shared bus to
// one consumer with a bounded wait, and counts dropped / overflowed frames.
module uart_rx_dispatch #(
    parameter int BYTE_SIZE  = uart_pkg::BYTE_SIZE,
    parameter int DATA_SIZE  = 64,
    parameter int NUM_DST    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [BYTE_SIZE-1:0] i_opt,
    input  logic [BYTE_SIZE-1:0] i_len,
    input  logic [DATA_SIZE-1:0] i_data,
    input  logic                 i_valid,
    output logic [NUM_DST-1:0]   o_dst_valid,
    input  logic [NUM_DST-1:0]   i_dst_ready,
    output logic [BYTE_SIZE-1:0] o_dst_opt,
    output logic [BYTE_SIZE-1:0] o_dst_len,
    output logic [DATA_SIZE-1:0] o_dst_data,
    input  logic                 i_clr_stat,
    output logic [BYTE_SIZE-1:0] o_drop_cnt,
    output logic                 o_overflow,
    output logic                 o_busy
);

    import uart_pkg::state_t;
    import uart_pkg::ST_IDLE;
    import uart_pkg::ST_CHECK;
    import uart_pkg::ST_OFFER;
    import uart_pkg::ST_DROP;
    import uart_pkg::dst_w;

    localparam int DST_W   = dst_w(NUM_DST);
    localparam int MAX_LEN = DATA_SIZE / BYTE_SIZE;
    localparam int FW      = 2 * BYTE_SIZE + DATA_SIZE;
    localparam int TMO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // Saturating add of up to two events onto the drop counter.
    function automatic logic [BYTE_SIZE-1:0] sat_add(input logic [BYTE_SIZE-1:0] a,
                                                     input logic [1:0]           b);
        logic [BYTE_SIZE:0] sum;
        sum = {1'b0, a} + {{(BYTE_SIZE - 1){1'b0}}, b};
        return sum[BYTE_SIZE] ? '1 : sum[BYTE_SIZE-1:0];
    endfunction

    state_t               state_q, state_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [BYTE_SIZE-1:0] drop_cnt_q, drop_cnt_d;
    logic                 ovf_q, ovf_d;

    logic                 fifo_pop, fifo_full, fifo_empty, fifo_ovf;
    logic [FW-1:0]        frame_q;
    logic [BYTE_SIZE-1:0] f_opt, f_len;
    logic [DATA_SIZE-1:0] f_data;
    logic [DST_W-1:0]     dst;
    logic                 routable, drop_evt;
    logic [NUM_DST-1:0]   dst_valid;
    logic [1:0]           drop_inc;

    // The FIFO's registered head doubles as the frame register: it only
    // changes on a pop, and pops happen only in IDLE.
    uart_frame_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .push_i  (i_valid),
        .wdata_i ({i_opt, i_len, i_data}),
        .pop_i   (fifo_pop),
        .rdata_o (frame_q),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {f_opt, f_len, f_data} = frame_q;
    assign dst      = f_opt[DST_W-1:0];
    assign routable = ((f_opt >> DST_W) == '0) && (f_len != '0) &&
                      (32'(f_len) <= MAX_LEN);
    assign fifo_ovf = i_valid && fifo_full && !fifo_pop;
    assign drop_inc = {1'b0, drop_evt} + {1'b0, fifo_ovf};

    // Next-state, timeout countdown, pop request and offer decode.
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        fifo_pop  = 1'b0;
        drop_evt  = 1'b0;
        dst_valid = '0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (routable) begin
                    tmo_d   = TMO_W'(TIMEOUT);
                    state_d = ST_OFFER;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_OFFER: begin
                dst_valid[dst] = 1'b1;
                if (i_dst_ready[dst]) begin
                    state_d = ST_IDLE;
                end else if (tmo_q == '0) begin
                    state_d = ST_DROP;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            ST_DROP: begin
                drop_evt = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Statistics: a clear wipes the old value, same-cycle events still land.
    always_comb begin
        drop_cnt_d = sat_add(i_clr_stat ? '0 : drop_cnt_q, drop_inc);
        ovf_d      = (i_clr_stat ? 1'b0 : ovf_q) | fifo_ovf;
    end

    // Control and statistics registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            tmo_q      <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Bus is gated to zero outside OFFER so the frame register needs no reset.
    assign o_dst_valid = dst_valid;
    assign o_dst_opt   = (state_q == ST_OFFER) ? f_opt  : '0;
    assign o_dst_len   = (state_q == ST_OFFER) ? f_len  : '0;
    assign o_dst_data  = (state_q == ST_OFFER) ? f_data : '0;
    assign o_drop_cnt  = drop_cnt_q;
    assign o_overflow  = ovf_q;
    assign o_busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule
